// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the boot-time program loader: the loader state
// encoding and the byte stride of each target memory.
//
// Contents:
//   state_t              - loader states IDLE, IMEM, DMEM, DRAIN, RUN
//   IMEM_BYTES_PER_WORD  - byte stride between instruction-memory words
//   DMEM_BYTES_PER_WORD  - byte stride between data-memory words
package program_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      IMEM  = 3'd1,
      DMEM  = 3'd2,
      DRAIN = 3'd3,
      RUN   = 3'd4
   } state_t;

   localparam int IMEM_BYTES_PER_WORD = 4;
   localparam int DMEM_BYTES_PER_WORD = 8;

endpackage

// File: rtl/program_loader_if.sv
// program_loader_if
// Bundles the loader's input word stream and both external memory write
// ports.
//
// Signals:
//   in_valid / in_ready / in_data      - 64-bit valid/ready word stream
//   addr_ext / wen_ext / wdata_ext     - instruction-memory write port
//   addr_ext_2 / wen_ext_2 / wdata_ext_2 - data-memory write port
//
// Modports:
//   master - host side: drives the stream, observes the write ports
//   slave  - loader side: accepts the stream, drives the write ports
interface program_loader_if;

   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_data;

   logic [63:0] addr_ext;
   logic        wen_ext;
   logic [31:0] wdata_ext;

   logic [63:0] addr_ext_2;
   logic        wen_ext_2;
   logic [63:0] wdata_ext_2;

   modport master (
      output in_valid, in_data,
      input  in_ready,
      input  addr_ext, wen_ext, wdata_ext,
      input  addr_ext_2, wen_ext_2, wdata_ext_2
   );

   modport slave (
      input  in_valid, in_data,
      output in_ready,
      output addr_ext, wen_ext, wdata_ext,
      output addr_ext_2, wen_ext_2, wdata_ext_2
   );

endinterface

// File: rtl/load_counter.sv
// load_counter
// Beat counter for one memory phase. It captures the phase length on load,
// counts accepted beats, and flags the beat that will complete the phase.
//
// Ports:
//   clk, arst_n - clock, asynchronous active-low reset
//   load        - restart at 0 and capture limit
//   limit       - number of beats in this phase
//   inc         - one beat accepted this cycle
//   count       - index of the next beat (also its word offset)
//   last        - the next beat is the final one of the phase
module load_counter #(
   parameter int WIDTH = 10
) (
   input  logic             clk,
   input  logic             arst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] limit,
   input  logic             inc,
   output logic [WIDTH-1:0] count,
   output logic             last
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] count_q;
   logic [WIDTH-1:0] limit_q;

   // The counter is one bit wider than the largest beat index, so it can hold
   // the full depth and never wraps on a legal load.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         count_q <= '0;
         limit_q <= '0;
      end else if (load) begin
         count_q <= '0;
         limit_q <= limit;
      end else if (inc) begin
         count_q <= count_q + ONE;
      end
   end

   assign count = count_q;
   assign last  = ((count_q + ONE) == limit_q);

endmodule

// File: rtl/program_loader.sv
// program_loader
// Boot-time loader in front of the CPU. It streams an image from the host
// into instruction memory, then data memory, keeps a wrapping checksum of
// every accepted word, and finally enables the CPU.
//
// Ports:
//   clk, arst_n   - clock, asynchronous active-low reset
//   start         - load request, honoured only in IDLE
//   imem_words    - instruction words to load (latched on accepted start)
//   dmem_words    - data words to load (latched on accepted start)
//   halt          - stop the running CPU, back to IDLE
//   bus           - word stream and both memory write ports (slave side)
//   cpu_enable    - high only in RUN
//   busy          - high in IMEM, DMEM or DRAIN
//   error         - sticky flag for an oversize request
//   checksum      - modulo 2^64 sum of accepted words
module program_loader
   import program_loader_pkg::*;
#(
   parameter int IMEM_DEPTH = 512,
   parameter int DMEM_DEPTH = 1024
) (
   input  logic                    clk,
   input  logic                    arst_n,
   input  logic                    start,
   input  logic [9:0]              imem_words,
   input  logic [10:0]             dmem_words,
   input  logic                    halt,
   program_loader_if.slave         bus,
   output logic                    cpu_enable,
   output logic                    busy,
   output logic                    error,
   output logic [63:0]             checksum
);

   localparam logic [31:0] IMEM_LIMIT = IMEM_DEPTH;
   localparam logic [31:0] DMEM_LIMIT = DMEM_DEPTH;

   state_t      state_q;
   state_t      state_d;

   logic        in_ready_q;
   logic        cpu_enable_q;
   logic        busy_q;
   logic        error_q;
   logic [63:0] checksum_q;
   logic        dmem_pending_q;

   logic [63:0] addr_q;
   logic        wen_q;
   logic [31:0] wdata_q;
   logic [63:0] addr2_q;
   logic        wen2_q;
   logic [63:0] wdata2_q;

   logic        oversize;
   logic        start_ok;
   logic        start_bad;
   logic        beat;
   logic        imem_beat;
   logic        dmem_beat;

   logic [9:0]  imem_count;
   logic        imem_last;
   logic [10:0] dmem_count;
   logic        dmem_last;

   assign oversize  = (32'(imem_words) > IMEM_LIMIT) || (32'(dmem_words) > DMEM_LIMIT);
   assign start_ok  = start && (state_q == IDLE) && !oversize;
   assign start_bad = start && (state_q == IDLE) && oversize;

   assign beat      = bus.in_valid && in_ready_q;
   assign imem_beat = beat && (state_q == IMEM);
   assign dmem_beat = beat && (state_q == DMEM);

   load_counter #(.WIDTH(10)) u_imem_counter (
      .clk    (clk),
      .arst_n (arst_n),
      .load   (start_ok),
      .limit  (imem_words),
      .inc    (imem_beat),
      .count  (imem_count),
      .last   (imem_last)
   );

   load_counter #(.WIDTH(11)) u_dmem_counter (
      .clk    (clk),
      .arst_n (arst_n),
      .load   (start_ok),
      .limit  (dmem_words),
      .inc    (dmem_beat),
      .count  (dmem_count),
      .last   (dmem_last)
   );

   // Next-state logic. Empty phases are skipped straight away, so IMEM and
   // DMEM are only ever entered with at least one beat to take.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (start_ok) begin
               if (imem_words != 10'd0) begin
                  state_d = IMEM;
               end else if (dmem_words != 11'd0) begin
                  state_d = DMEM;
               end else begin
                  state_d = DRAIN;
               end
            end
         end
         IMEM: begin
            if (imem_beat && imem_last) begin
               state_d = dmem_pending_q ? DMEM : DRAIN;
            end
         end
         DMEM: begin
            if (dmem_beat && dmem_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: state_d = RUN;
         RUN: begin
            if (halt) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State register. The status outputs are decoded from the next state so
   // they stay registered yet line up with the state they describe.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q      <= IDLE;
         in_ready_q   <= 1'b0;
         busy_q       <= 1'b0;
         cpu_enable_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= (state_d == IMEM) || (state_d == DMEM);
         busy_q       <= (state_d == IMEM) || (state_d == DMEM) || (state_d == DRAIN);
         cpu_enable_q <= (state_d == RUN);
      end
   end

   // Memory write ports: each accepted beat becomes a one-cycle write pulse
   // in the following cycle. Address and data hold between writes.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wen_q    <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wen2_q   <= 1'b0;
         addr2_q  <= '0;
         wdata2_q <= '0;
      end else begin
         wen_q  <= imem_beat;
         wen2_q <= dmem_beat;
         if (imem_beat) begin
            addr_q  <= {54'd0, imem_count} * 64'(IMEM_BYTES_PER_WORD);
            wdata_q <= bus.in_data[31:0];
         end
         if (dmem_beat) begin
            addr2_q  <= {53'd0, dmem_count} * 64'(DMEM_BYTES_PER_WORD);
            wdata2_q <= bus.in_data;
         end
      end
   end

   // Checksum, error flag and the latched "data phase follows" bit. An
   // accepted start clears both the checksum and any earlier error.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         checksum_q     <= '0;
         error_q        <= 1'b0;
         dmem_pending_q <= 1'b0;
      end else if (start_ok) begin
         checksum_q     <= '0;
         error_q        <= 1'b0;
         dmem_pending_q <= (dmem_words != 11'd0);
      end else begin
         if (start_bad) begin
            error_q <= 1'b1;
         end
         if (imem_beat) begin
            checksum_q <= checksum_q + {32'd0, bus.in_data[31:0]};
         end else if (dmem_beat) begin
            checksum_q <= checksum_q + bus.in_data;
         end
      end
   end

   assign bus.in_ready    = in_ready_q;
   assign bus.addr_ext    = addr_q;
   assign bus.wen_ext     = wen_q;
   assign bus.wdata_ext   = wdata_q;
   assign bus.addr_ext_2  = addr2_q;
   assign bus.wen_ext_2   = wen2_q;
   assign bus.wdata_ext_2 = wdata2_q;

   assign cpu_enable = cpu_enable_q;
   assign busy       = busy_q;
   assign error      = error_q;
   assign checksum   = checksum_q;

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Directed bench for program_loader. A beat-indexed model predicts every
// registered output each cycle; hand-computed literals pin the key results.
module tb_program_loader;

   localparam int M_IDLE  = 0;
   localparam int M_LOAD  = 1;
   localparam int M_DRAIN = 2;
   localparam int M_RUN   = 3;

   logic        clk = 1'b0;
   logic        arst_n;
   logic        start;
   logic [9:0]  imem_words;
   logic [10:0] dmem_words;
   logic        halt;
   logic        cpu_enable;
   logic        busy;
   logic        error;
   logic [63:0] checksum;

   int pass_count  = 0;
   int total_count = 0;

   // Model state and the outputs it expects from the DUT.
   int          m_mode   = M_IDLE;
   int          m_beats  = 0;
   int          m_imem_n = 0;
   int          m_dmem_n = 0;
   logic        e_ready  = 1'b0;
   logic        e_wen    = 1'b0;
   logic [63:0] e_addr   = '0;
   logic [31:0] e_wdata  = '0;
   logic        e_wen2   = 1'b0;
   logic [63:0] e_addr2  = '0;
   logic [63:0] e_wdata2 = '0;
   logic        e_cpu    = 1'b0;
   logic        e_busy   = 1'b0;
   logic        e_err    = 1'b0;
   logic [63:0] e_csum   = '0;

   logic [63:0] imem_addr_log[$];
   logic [63:0] imem_data_log[$];
   logic [63:0] dmem_addr_log[$];
   logic [63:0] dmem_data_log[$];

   program_loader_if io();

   program_loader #(.IMEM_DEPTH(512), .DMEM_DEPTH(1024)) dut (
      .clk        (clk),
      .arst_n     (arst_n),
      .start      (start),
      .imem_words (imem_words),
      .dmem_words (dmem_words),
      .halt       (halt),
      .bus        (io.slave),
      .cpu_enable (cpu_enable),
      .busy       (busy),
      .error      (error),
      .checksum   (checksum)
   );

   always #5 clk = ~clk;

   // Watchdog so a stuck run still ends with a visible failure.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      total_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
      end
   endtask

   function automatic logic [63:0] logAt(input logic [63:0] q[$], input int i);
      if (i < q.size()) return q[i];
      return 64'hFFFF_FFFF_FFFF_FFFF;
   endfunction

   // Move to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   // Drive the control inputs for exactly one cycle.
   task automatic applyStimulus(input logic s, input logic [9:0] iw, input logic [10:0] dw, input logic h);
      start      = s;
      imem_words = iw;
      dmem_words = dw;
      halt       = h;
      tick();
      start = 1'b0;
      halt  = 1'b0;
   endtask

   // Offer one word and hold it until it is taken, within a cycle budget.
   task automatic sendBeat(input logic [63:0] data);
      int waited = 0;
      io.in_valid = 1'b1;
      io.in_data  = data;
      while (!io.in_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!io.in_ready) begin
         total_count++;
         $display("[TB] FAIL beat_timeout: in_ready got 0, expected 1 within 20 cycles");
      end
      tick();
      io.in_valid = 1'b0;
   endtask

   task automatic clearLogs();
      imem_addr_log.delete();
      imem_data_log.delete();
      dmem_addr_log.delete();
      dmem_data_log.delete();
   endtask

   // Model: beats are numbered across the whole load; the first imem_n go to
   // instruction memory at 4*k, the rest to data memory at 8*(k-imem_n).
   always @(posedge clk or negedge arst_n) begin : model_step
      int          nxt_mode;
      int          nxt_beats;
      int          nxt_imem;
      int          nxt_dmem;
      logic        nxt_err;
      logic        nxt_wen;
      logic        nxt_wen2;
      logic [63:0] nxt_csum;
      logic [63:0] nxt_addr;
      logic [31:0] nxt_wdata;
      logic [63:0] nxt_addr2;
      logic [63:0] nxt_wdata2;
      if (!arst_n) begin
         m_mode   <= M_IDLE;
         m_beats  <= 0;
         m_imem_n <= 0;
         m_dmem_n <= 0;
         e_ready  <= 1'b0;
         e_wen    <= 1'b0;
         e_addr   <= '0;
         e_wdata  <= '0;
         e_wen2   <= 1'b0;
         e_addr2  <= '0;
         e_wdata2 <= '0;
         e_cpu    <= 1'b0;
         e_busy   <= 1'b0;
         e_err    <= 1'b0;
         e_csum   <= '0;
      end else begin
         nxt_mode   = m_mode;
         nxt_beats  = m_beats;
         nxt_imem   = m_imem_n;
         nxt_dmem   = m_dmem_n;
         nxt_err    = e_err;
         nxt_csum   = e_csum;
         nxt_wen    = 1'b0;
         nxt_wen2   = 1'b0;
         nxt_addr   = e_addr;
         nxt_wdata  = e_wdata;
         nxt_addr2  = e_addr2;
         nxt_wdata2 = e_wdata2;
         case (m_mode)
            M_IDLE: begin
               if (start) begin
                  if (int'(imem_words) > 512 || int'(dmem_words) > 1024) begin
                     nxt_err = 1'b1;
                  end else begin
                     nxt_err   = 1'b0;
                     nxt_csum  = '0;
                     nxt_imem  = int'(imem_words);
                     nxt_dmem  = int'(dmem_words);
                     nxt_beats = 0;
                     nxt_mode  = (nxt_imem + nxt_dmem == 0) ? M_DRAIN : M_LOAD;
                  end
               end
            end
            M_LOAD: begin
               if (io.in_valid && e_ready) begin
                  if (m_beats < m_imem_n) begin
                     nxt_wen   = 1'b1;
                     nxt_addr  = 64'(4 * m_beats);
                     nxt_wdata = io.in_data[31:0];
                     nxt_csum  = e_csum + {32'd0, io.in_data[31:0]};
                  end else begin
                     nxt_wen2   = 1'b1;
                     nxt_addr2  = 64'(8 * (m_beats - m_imem_n));
                     nxt_wdata2 = io.in_data;
                     nxt_csum   = e_csum + io.in_data;
                  end
                  nxt_beats = m_beats + 1;
                  if (nxt_beats == m_imem_n + m_dmem_n) nxt_mode = M_DRAIN;
               end
            end
            M_DRAIN: nxt_mode = M_RUN;
            default: begin
               if (halt) nxt_mode = M_IDLE;
            end
         endcase
         m_mode   <= nxt_mode;
         m_beats  <= nxt_beats;
         m_imem_n <= nxt_imem;
         m_dmem_n <= nxt_dmem;
         e_err    <= nxt_err;
         e_csum   <= nxt_csum;
         e_wen    <= nxt_wen;
         e_addr   <= nxt_addr;
         e_wdata  <= nxt_wdata;
         e_wen2   <= nxt_wen2;
         e_addr2  <= nxt_addr2;
         e_wdata2 <= nxt_wdata2;
         e_ready  <= (nxt_mode == M_LOAD);
         e_busy   <= (nxt_mode == M_LOAD) || (nxt_mode == M_DRAIN);
         e_cpu    <= (nxt_mode == M_RUN);
      end
   end

   // Per-cycle comparison against the model, plus a log of observed writes.
   always @(negedge clk) begin
      if (arst_n) begin
         checkOutput("in_ready", io.in_ready, e_ready);
         checkOutput("wen_ext", io.wen_ext, e_wen);
         checkOutput("wen_ext_2", io.wen_ext_2, e_wen2);
         checkOutput("wen_exclusive", io.wen_ext & io.wen_ext_2, 64'd0);
         if (e_wen) begin
            checkOutput("addr_ext", io.addr_ext, e_addr);
            checkOutput("wdata_ext", io.wdata_ext, e_wdata);
         end
         if (e_wen2) begin
            checkOutput("addr_ext_2", io.addr_ext_2, e_addr2);
            checkOutput("wdata_ext_2", io.wdata_ext_2, e_wdata2);
         end
         checkOutput("cpu_enable", cpu_enable, e_cpu);
         checkOutput("busy", busy, e_busy);
         checkOutput("error", error, e_err);
         checkOutput("checksum", checksum, e_csum);
         if (io.wen_ext) begin
            imem_addr_log.push_back(io.addr_ext);
            imem_data_log.push_back({32'd0, io.wdata_ext});
         end
         if (io.wen_ext_2) begin
            dmem_addr_log.push_back(io.addr_ext_2);
            dmem_data_log.push_back(io.wdata_ext_2);
         end
      end
   end

   initial begin
      arst_n      = 1'b0;
      start       = 1'b0;
      halt        = 1'b0;
      imem_words  = '0;
      dmem_words  = '0;
      io.in_valid = 1'b0;
      io.in_data  = '0;

      // Reset state.
      #2;
      checkOutput("rst_in_ready", io.in_ready, 64'd0);
      checkOutput("rst_wen_ext", io.wen_ext, 64'd0);
      checkOutput("rst_wen_ext_2", io.wen_ext_2, 64'd0);
      checkOutput("rst_addr_ext", io.addr_ext, 64'd0);
      checkOutput("rst_addr_ext_2", io.addr_ext_2, 64'd0);
      checkOutput("rst_cpu_enable", cpu_enable, 64'd0);
      checkOutput("rst_busy", busy, 64'd0);
      checkOutput("rst_error", error, 64'd0);
      checkOutput("rst_checksum", checksum, 64'd0);
      @(posedge clk);
      #3;
      arst_n = 1'b1;
      tick();

      // Nominal 3/2 load.
      $display("[TB] nominal load");
      clearLogs();
      applyStimulus(1'b1, 10'd3, 11'd2, 1'b0);
      sendBeat(64'h13);
      sendBeat(64'h0050_0093);
      sendBeat(64'h63);
      sendBeat(64'hAA);
      sendBeat(64'hBB);
      @(negedge clk);
      checkOutput("nom_last_write", io.wen_ext_2, 64'd1);
      checkOutput("nom_enable_n1", cpu_enable, 64'd0);
      checkOutput("nom_ready_drop", io.in_ready, 64'd0);
      @(negedge clk);
      checkOutput("nom_enable_n2", cpu_enable, 64'd1);
      checkOutput("nom_busy_run", busy, 64'd0);
      checkOutput("nom_imem_count", imem_addr_log.size(), 64'd3);
      checkOutput("nom_imem_addr0", logAt(imem_addr_log, 0), 64'd0);
      checkOutput("nom_imem_addr1", logAt(imem_addr_log, 1), 64'd4);
      checkOutput("nom_imem_addr2", logAt(imem_addr_log, 2), 64'd8);
      checkOutput("nom_imem_data1", logAt(imem_data_log, 1), 64'h0050_0093);
      checkOutput("nom_dmem_count", dmem_addr_log.size(), 64'd2);
      checkOutput("nom_dmem_addr0", logAt(dmem_addr_log, 0), 64'd0);
      checkOutput("nom_dmem_addr1", logAt(dmem_addr_log, 1), 64'd8);
      checkOutput("nom_dmem_data1", logAt(dmem_data_log, 1), 64'hBB);
      checkOutput("nom_checksum", checksum, 64'h0050_026E);
      checkOutput("nom_model_checksum", e_csum, 64'h0050_026E);

      // Halt in RUN together with start: halt wins.
      $display("[TB] halt with start");
      tick();
      applyStimulus(1'b1, 10'd2, 11'd2, 1'b1);
      @(negedge clk);
      checkOutput("halt_enable", cpu_enable, 64'd0);
      checkOutput("halt_busy", busy, 64'd0);
      idle(2);
      @(negedge clk);
      checkOutput("halt_start_ignored", io.in_ready, 64'd0);

      // Stream stall 1-0-0-1; upper bits of an IMEM word are ignored.
      $display("[TB] stream stall");
      tick();
      clearLogs();
      applyStimulus(1'b1, 10'd3, 11'd0, 1'b0);
      sendBeat(64'hDEAD_BEEF_0000_0001);
      idle(2);
      sendBeat(64'h2);
      sendBeat(64'h3);
      idle(3);
      checkOutput("stall_imem_count", imem_addr_log.size(), 64'd3);
      checkOutput("stall_addr1", logAt(imem_addr_log, 1), 64'd4);
      checkOutput("stall_addr2", logAt(imem_addr_log, 2), 64'd8);
      checkOutput("stall_data0", logAt(imem_data_log, 0), 64'd1);
      checkOutput("stall_dmem_count", dmem_addr_log.size(), 64'd0);
      checkOutput("stall_checksum", checksum, 64'd6);
      applyStimulus(1'b0, 10'd0, 11'd0, 1'b1);

      // Empty load 0/0.
      $display("[TB] empty load");
      clearLogs();
      applyStimulus(1'b1, 10'd0, 11'd0, 1'b0);
      @(negedge clk);
      checkOutput("empty_drain_busy", busy, 64'd1);
      checkOutput("empty_enable_n1", cpu_enable, 64'd0);
      @(negedge clk);
      checkOutput("empty_enable_n2", cpu_enable, 64'd1);
      checkOutput("empty_no_writes", imem_addr_log.size() + dmem_addr_log.size(), 64'd0);
      tick();
      applyStimulus(1'b0, 10'd0, 11'd0, 1'b1);

      // Oversize requests, then a legal 0/1 load clears the error.
      $display("[TB] oversize request");
      clearLogs();
      applyStimulus(1'b1, 10'd513, 11'd0, 1'b0);
      @(negedge clk);
      checkOutput("over_error", error, 64'd1);
      checkOutput("over_busy", busy, 64'd0);
      tick();
      applyStimulus(1'b1, 10'd0, 11'd1025, 1'b0);
      @(negedge clk);
      checkOutput("over_dmem_error", error, 64'd1);
      checkOutput("over_dmem_ready", io.in_ready, 64'd0);
      tick();
      applyStimulus(1'b1, 10'd0, 11'd1, 1'b0);
      @(negedge clk);
      checkOutput("legal_clears_error", error, 64'd0);
      tick();
      sendBeat(64'h55);
      idle(3);
      checkOutput("d_only_imem_count", imem_addr_log.size(), 64'd0);
      checkOutput("d_only_dmem_count", dmem_addr_log.size(), 64'd1);
      checkOutput("d_only_addr0", logAt(dmem_addr_log, 0), 64'd0);
      checkOutput("d_only_checksum", checksum, 64'h55);
      applyStimulus(1'b0, 10'd0, 11'd0, 1'b1);

      // Start during DMEM is ignored.
      $display("[TB] start during data phase");
      clearLogs();
      applyStimulus(1'b1, 10'd1, 11'd2, 1'b0);
      sendBeat(64'h10);
      applyStimulus(1'b1, 10'd5, 11'd5, 1'b0);
      sendBeat(64'h20);
      sendBeat(64'h30);
      idle(3);
      checkOutput("ign_imem_count", imem_addr_log.size(), 64'd1);
      checkOutput("ign_dmem_count", dmem_addr_log.size(), 64'd2);
      checkOutput("ign_dmem_addr1", logAt(dmem_addr_log, 1), 64'd8);
      checkOutput("ign_checksum", checksum, 64'h60);
      checkOutput("ign_enable", cpu_enable, 64'd1);
      applyStimulus(1'b0, 10'd0, 11'd0, 1'b1);

      // Reset after 2 of 4 IMEM beats, then a fresh load.
      $display("[TB] reset mid-load");
      applyStimulus(1'b1, 10'd4, 11'd0, 1'b0);
      sendBeat(64'h1);
      sendBeat(64'h2);
      arst_n = 1'b0;
      #1;
      checkOutput("arst_wen_ext", io.wen_ext, 64'd0);
      checkOutput("arst_addr_ext", io.addr_ext, 64'd0);
      checkOutput("arst_in_ready", io.in_ready, 64'd0);
      checkOutput("arst_busy", busy, 64'd0);
      checkOutput("arst_checksum", checksum, 64'd0);
      @(negedge clk);
      #2;
      arst_n = 1'b1;
      tick();
      clearLogs();
      applyStimulus(1'b1, 10'd2, 11'd0, 1'b0);
      sendBeat(64'h7);
      sendBeat(64'h8);
      idle(3);
      checkOutput("rl_imem_count", imem_addr_log.size(), 64'd2);
      checkOutput("rl_addr0", logAt(imem_addr_log, 0), 64'd0);
      checkOutput("rl_addr1", logAt(imem_addr_log, 1), 64'd4);
      checkOutput("rl_checksum", checksum, 64'd15);

      $display("%0d/%0d checks passed", pass_count, total_count);
      $finish;
   end

endmodule
